// File: rtl/placar_ataque.sv
// -----------------------------------------------------------------------------
// placar_ataque -- attack-game scoreboard.
//
// Sits after the combinational attack decoder. Each confirmed shot samples the
// six target-hit lines, accumulates sticky per-target flags, counts attempts,
// pulses hit/miss, and declares victory (all six targets) or defeat (attempts
// exhausted).
//
// Optional feature: define ATAQUE_DEBOUNCE_EN to insert a DEB_CICLOS-cycle
// stability filter between the synchronizer and the edge detector.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   confirma   raw shot-confirm button (asynchronous to clk)
//   novo_jogo  synchronous game clear (level)
//   s_in[5:0]  target-hit lines from the decoder (bit0 = s1)
//   alvos[5:0] sticky hit flags
//   tentativas attempts consumed so far
//   acerto     one-cycle pulse: shot hit at least one new target
//   erro       one-cycle pulse: shot hit no new target
//   vitoria    level: all targets hit
//   derrota    level: attempts exhausted without victory
//   ocupado    high whenever the FSM is not in ESPERA
// -----------------------------------------------------------------------------
module placar_ataque #(
  parameter int MAX_TENT   = 15,
  parameter int DEB_CICLOS = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirma,
  input  logic       novo_jogo,
  input  logic [5:0] s_in,
  output logic [5:0] alvos,
  output logic [3:0] tentativas,
  output logic       acerto,
  output logic       erro,
  output logic       vitoria,
  output logic       derrota,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    AVALIA = 2'd1,
    FIM    = 2'd2
  } estado_t;

  localparam logic [4:0] MAX_T   = 5'(MAX_TENT);
  localparam logic [5:0] TODOS   = 6'h3F;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, optional debounce, edge detector.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic nivel;               // conditioned confirma level
  logic prev_q;
  logic disparo_d, disparo_q;

  // NOTE: asynchronous reset is in the sensitivity list so state clears
  // immediately on rst, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the *old* sync1_q,
      // which is what builds the two-stage pipeline.
      sync1_q <= confirma;
      sync2_q <= sync1_q;
    end
  end

`ifdef ATAQUE_DEBOUNCE_EN
  localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS + 1) : 1;
  localparam logic [CW-1:0] DEB_FIM = CW'(DEB_CICLOS - 1);

  logic [CW-1:0] deb_cnt_d, deb_cnt_q;
  logic          deb_d, deb_q;

  // Accept a new level only after it differs from the held level for
  // DEB_CICLOS consecutive cycles; any bounce back restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    deb_d     = deb_q;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_FIM) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
    end
  end

  assign nivel = deb_q;
`else
  assign nivel = sync2_q;
`endif

  // Registered rising-edge pulse: holding the button yields one disparo.
  assign disparo_d = nivel & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= 1'b0;
      disparo_q <= 1'b0;
    end else begin
      prev_q    <= nivel;
      disparo_q <= disparo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoring datapath.
  // ---------------------------------------------------------------------------
  estado_t    estado_d, estado_q;
  logic [5:0] alvos_d, alvos_q;
  logic [3:0] tent_d, tent_q;
  logic       acerto_d, acerto_q;
  logic       erro_d, erro_q;
  logic       vit_d, vit_q;
  logic       der_d, der_q;

  logic [5:0] novos;
  logic [5:0] alvos_or;
  logic [4:0] tent_inc;      // one bit wider so the compare cannot wrap
  logic       ganhou, esgotou;

  assign novos    = s_in & ~alvos_q;
  assign alvos_or = alvos_q | s_in;
  assign tent_inc = {1'b0, tent_q} + 5'd1;
  assign ganhou   = (alvos_or == TODOS);
  assign esgotou  = (tent_inc == MAX_T);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    alvos_d  = alvos_q;
    tent_d   = tent_q;
    acerto_d = 1'b0;         // pulses fall back to 0 every cycle
    erro_d   = 1'b0;
    vit_d    = vit_q;
    der_d    = der_q;
    if (novo_jogo) begin
      alvos_d = '0;
      tent_d  = '0;
      vit_d   = 1'b0;
      der_d   = 1'b0;
    end else if (estado_q == AVALIA) begin
      alvos_d  = alvos_or;
      tent_d   = tent_inc[3:0];
      acerto_d = (novos != 6'd0);
      erro_d   = (novos == 6'd0);
      vit_d    = ganhou;
      der_d    = !ganhou && esgotou;   // victory wins on the final attempt
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alvos_q  <= '0;
      tent_q   <= '0;
      acerto_q <= 1'b0;
      erro_q   <= 1'b0;
      vit_q    <= 1'b0;
      der_q    <= 1'b0;
    end else begin
      alvos_q  <= alvos_d;
      tent_q   <= tent_d;
      acerto_q <= acerto_d;
      erro_q   <= erro_d;
      vit_q    <= vit_d;
      der_q    <= der_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado_q <= ESPERA;
    else     estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    if (novo_jogo) begin
      estado_d = ESPERA;     // a disparo in this cycle is dropped
    end else begin
      unique case (estado_q)
        ESPERA:  if (disparo_q) estado_d = AVALIA;
        AVALIA:  estado_d = (ganhou || esgotou) ? FIM : ESPERA;
        FIM:     estado_d = FIM;
        default: estado_d = ESPERA;
      endcase
    end
  end

  always_comb begin
    ocupado = (estado_q != ESPERA);
  end

  assign alvos      = alvos_q;
  assign tentativas = tent_q;
  assign acerto     = acerto_q;
  assign erro       = erro_q;
  assign vitoria    = vit_q;
  assign derrota    = der_q;

endmodule

// File: doc/placar_ataque.md
# placar_ataque

Sequential scoreboard that sits directly downstream of the combinational attack decoder. On each confirmed player shot it samples the decoder's six target-hit lines and accumulates sticky per-target hit flags. It also counts attempts, pulses a hit/miss indication, and declares victory when all six targets are hit or defeat when attempts run out. Its outputs drive the board LEDs and the 7-segment attempt display.

## Interface
Parameters:
- MAX_TENT, 15: attempts allowed per game (1..15).
- DEB_CICLOS, 500000: debounce stability window in clock cycles. Used only when ATAQUE_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- confirma  in  1  raw shot-confirm push button, asynchronous to clk, active-high.
- novo_jogo  in  1  synchronous game clear, active-high level, sampled every cycle.
- s_in  in  6  hit lines s1..s6 from the attack decoder (bit0 = s1); stable while the switches are stable.
- alvos  out  6  sticky hit flags, one per target.
- tentativas  out  4  attempts consumed so far.
- acerto  out  1  one-cycle pulse: the shot hit at least one not-yet-hit target.
- erro  out  1  one-cycle pulse: the shot hit no new target.
- vitoria  out  1  level: all six targets hit.
- derrota  out  1  level: attempts exhausted without victory.
- ocupado  out  1  high when the FSM is not in ESPERA.

## Operation
- Input conditioning:
  - confirma passes through a 2-flop synchronizer, then a rising-edge detector producing `disparo` (one-cycle pulse).
  - Holding confirma high produces exactly one disparo.
- FSM states: ESPERA, AVALIA, FIM.
- ESPERA:
  - disparo moves to AVALIA.
  - Any other cycle stays in ESPERA.
- AVALIA (exactly one cycle): compute novos = s_in & ~alvos. On the exit edge:
  - alvos <= alvos | s_in.
  - tentativas <= tentativas + 1.
  - acerto <= (novos != 0); erro <= (novos == 0).
  - If (alvos | s_in) == 6'h3F, set vitoria and go to FIM.
  - Else if tentativas + 1 == MAX_TENT, set derrota and go to FIM.
  - Otherwise return to ESPERA.
- Scoring rules:
  - Victory takes priority when the last attempt hits the last target.
  - Re-hitting an already flagged target counts as erro and still consumes an attempt.
  - s_in == 0 counts as erro.
- FIM: disparo is ignored. vitoria/derrota and alvos hold until novo_jogo or rst.
- novo_jogo, in any state, has priority over everything except rst. On the next edge:
  - alvos, tentativas, vitoria, derrota, acerto and erro clear.
  - The FSM goes to ESPERA.
  - A disparo in that same cycle is dropped.
- tentativas never exceeds MAX_TENT and never wraps.

## Timing
- Reset values: alvos = 0, tentativas = 0, acerto = 0, erro = 0, vitoria = 0, derrota = 0, ocupado = 0, FSM = ESPERA, synchronizer flops = 0.
- rst asserted mid-game returns everything to reset values immediately, asynchronously.
- Latency without debounce: confirma rise sampled at edge N gives disparo high in cycle N+2, FSM in AVALIA in N+3, outputs updated and acerto/erro pulsed in N+4.
- acerto and erro are registered, mutually exclusive, and high for exactly one cycle per shot.
- ocupado is high only during AVALIA, and in FIM.
- A second disparo arriving while in AVALIA is dropped. Presses must be at least 2 cycles apart at the synchronizer output to both count.
- s_in is sampled only in the AVALIA cycle.

## Configuration
- ATAQUE_DEBOUNCE_EN defined:
  - A counter between synchronizer and edge detector accepts a new confirma level only after it has been stable for DEB_CICLOS consecutive cycles.
  - Latency grows by DEB_CICLOS cycles.
  - Pulses shorter than DEB_CICLOS are ignored.
- ATAQUE_DEBOUNCE_EN undefined: no debounce logic; the synchronizer output feeds the edge detector directly. Benches use this mode.

## Test plan
- Reset then idle, with s_in = 6'h3F and no confirma -> all outputs 0, FSM stays in ESPERA.
- s_in = 6'h01 then one press -> 4 cycles later acerto = 1 for one cycle, alvos = 6'h01, tentativas = 1; repeat the same press -> erro pulse, alvos = 6'h01, tentativas = 2.
- Presses with s_in = 6'h03, 6'h0C, 6'h30 -> third shot gives alvos = 6'h3F, vitoria = 1, tentativas = 3; a further press leaves tentativas = 3.
- MAX_TENT = 15, fifteen presses with s_in = 0 -> fifteen erro pulses, derrota = 1, tentativas = 15 (no wrap); a 16th press is ignored.
- Defeat state, pulse novo_jogo for one cycle -> next edge clears all outputs; a press on the same cycle is not counted.
- Assert rst asynchronously during AVALIA -> outputs go to 0 immediately with no acerto/erro pulse; after release a new shot scores normally with tentativas = 1.
